// File: rtl/dmem_pkg.sv
// Shared encodings, pipeline stage record and byte-enable helper for dmem_pipe.
package dmem_pkg;

  // Access size encodings on req_size; 2'b00 is reserved and always errors.
  localparam logic [1:0] SIZE_ILLEGAL = 2'b00;
  localparam logic [1:0] SIZE_WORD    = 2'b01;
  localparam logic [1:0] SIZE_HALF    = 2'b10;
  localparam logic [1:0] SIZE_BYTE    = 2'b11;

  localparam logic ENABLED       = 1'b1;
  localparam logic WRITE_ENABLED = 1'b1;

  // One slot of the response pipeline. The raw word is carried and the
  // lane select / extension is done only at the last stage.
  typedef struct packed {
    logic        valid;
    logic        we;
    logic        err;
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  lane;
    logic [31:0] word;
  } stage_t;

  // Byte-lane mask for a store of the given size at the given lane.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SIZE_WORD: be = 4'b1111;
      SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_BYTE: be = 4'b0001 << lane;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_pipe_extend.sv
// Load lane select plus sign/zero extension, used on the final pipeline stage.
module dmem_extend
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half and widen it to 32 bits.
  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = word[{lane[1], 4'b0000} +: 16];
    data     = 32'h0;
    case (size)
      SIZE_WORD: data = word;
      SIZE_HALF: data = {{16{sign & half_sel[15]}}, half_sel};
      SIZE_BYTE: data = {{24{sign & byte_sel[7]}}, byte_sel};
      default:   data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_pipe.sv
// MEM-stage data memory: valid/ready request port, byte-enable stores,
// READ_LAT-deep registered response pipeline with stall, and error flagging.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready = rst_n && !stall. rsp_valid marks a response; while stall is high
// the response is held and must be ignored by the consumer, and it is consumed
// on the first cycle it is seen with stall low.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h10010000,
  parameter int          DEPTH     = 2048,
  parameter int          READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  stage_t           stage_q [READ_LAT];
  stage_t           stage_d [READ_LAT];

  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             in_range;
  logic             misaligned;
  logic             req_err;
  logic             accept;
  logic             wr_en;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  stage_t           last;
  logic [31:0]      ext_data;

  assign req_ready = rst_n && !stall;

  // Address decode, error classification and store lane replication.
  always_comb begin
    off  = req_addr - BASE_ADDR;
    idx  = off[IDX_W+1:2];
    lane = off[1:0];
    // Window is a power of two, so in range means no bits above the index.
    in_range = (off >> (IDX_W + 2)) == 32'h0;
    case (req_size)
      SIZE_WORD: misaligned = (lane != 2'b00);
      SIZE_HALF: misaligned = lane[0];
      SIZE_BYTE: misaligned = 1'b0;
      default:   misaligned = 1'b1;
    endcase
    req_err = !in_range || misaligned;
    accept  = req_valid && req_ready;
    wr_en   = accept && (req_we == WRITE_ENABLED) && !req_err;
    be      = byte_en(req_size, lane);
    case (req_size)
      SIZE_HALF: wdata_rep = {2{req_wdata[15:0]}};
      SIZE_BYTE: wdata_rep = {4{req_wdata[7:0]}};
      default:   wdata_rep = req_wdata;
    endcase
  end

  // Byte-enabled write in the accept cycle; array contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
      end
    end
  end

  // Next state of the response pipeline: load stage 0 on accept, shift
  // when unstalled, hold everything while stalled.
  always_comb begin
    for (int i = 0; i < READ_LAT; i++) stage_d[i] = stage_q[i];
    if (!stall) begin
      stage_d[0] = '0;
      if (accept) begin
        stage_d[0].valid = ENABLED;
        stage_d[0].we    = req_we;
        stage_d[0].err   = req_err;
        stage_d[0].size  = req_size;
        stage_d[0].sign  = req_sign;
        stage_d[0].lane  = lane;
        stage_d[0].word  = req_we ? 32'h0 : mem_q[idx];
      end
      for (int i = 1; i < READ_LAT; i++) stage_d[i] = stage_q[i-1];
    end
  end

  // Pipeline registers; reset drops every in-flight response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < READ_LAT; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign last = stage_q[READ_LAT-1];

  dmem_extend u_extend (
    .size (last.size),
    .sign (last.sign),
    .lane (last.lane),
    .word (last.word),
    .data (ext_data)
  );

  // Response outputs; data is forced to zero for stores and errors.
  always_comb begin
    rsp_valid = last.valid;
    rsp_err   = last.valid && last.err;
    rsp_rdata = (last.valid && !last.err && !last.we) ? ext_data : 32'h0;
  end

endmodule
